// File: rtl/mdu_pkg.sv
// Shared encodings and latencies for the multiply/divide unit and the E-stage decoder.
// Defining MDU_MADD_EN makes the MADD/MADDU/MSUB/MSUBU codes valid multi-cycle ops.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;
  localparam int CNT_W      = $clog2(DIV_CYCLES + 1);

  typedef logic [CNT_W-1:0] mdu_cnt_t;

  // True for codes that launch a RUN phase in this build.
  function automatic logic is_run_op(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_run_op = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_run_op = 1'b1;
`endif
      default: is_run_op = 1'b0;
    endcase
  endfunction

  function automatic mdu_cnt_t run_cycles(input logic [3:0] op);
    if (op == OP_DIV || op == OP_DIVU) run_cycles = mdu_cnt_t'(DIV_CYCLES);
    else                               run_cycles = mdu_cnt_t'(MUL_CYCLES);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Pipeline-side bundle of the multiply/divide unit: E-stage control in, busy and HI/LO out.
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, we, cancel, input busy, hi, lo);
  modport slave  (input start, op, a, b, we, cancel, output busy, hi, lo);
endinterface

// File: rtl/mdu_calc.sv
// Combinational 64-bit result for the latched op: {hi,lo} next value.
// Accumulate forms are present only when MDU_MADD_EN is defined.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic signed [63:0] a_s64;
  logic signed [63:0] b_s64;
  logic        [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic        [31:0] quo_s;
  logic        [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_zero;
  logic               div_ovf;

  assign a_s64  = {{32{a[31]}}, a};
  assign b_s64  = {{32{b[31]}}, b};
  assign prod_s = a_s64 * b_s64;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Operator semantics give truncation toward zero and dividend-signed remainder.
  assign a_s   = a;
  assign b_s   = b;
  assign quo_s = a_s / b_s;
  assign rem_s = a_s % b_s;
  assign quo_u = a / b;
  assign rem_u = a % b;

  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    result = {hi, lo};
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        if (div_zero)     result = {a, 32'hFFFF_FFFF};
        else if (div_ovf) result = {32'd0, 32'h8000_0000};
        else              result = {rem_s, quo_s};
      end
      OP_DIVU: begin
        if (div_zero) result = {a, 32'hFFFF_FFFF};
        else          result = {rem_u, quo_u};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + prod_s;
      OP_MADDU: result = {hi, lo} + prod_u;
      OP_MSUB:  result = {hi, lo} - prod_s;
      OP_MSUBU: result = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO: IDLE->RUN->IDLE with a down-counter, plus MTHI/MTLO.
// MDU_MADD_EN additionally enables the MADD/MSUB accumulate family.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state;
  mdu_cnt_t    count;
  mdu_op_e     op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] next_hilo;

  mdu_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (hi),
    .lo     (lo),
    .result (next_hilo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      count <= '0;
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == S_IDLE) begin
      if (start && !cancel && is_run_op(op)) begin
        op_q  <= mdu_op_e'(op);
        a_q   <= a;
        b_q   <= b;
        count <= run_cycles(op);
        state <= S_RUN;
        busy  <= 1'b1;
      end else if (we && !cancel && op == OP_MTHI) begin
        hi <= a;
      end else if (we && !cancel && op == OP_MTLO) begin
        lo <= a;
      end
    end else begin
      // Last RUN cycle: counter reaches zero on this edge together with the HI/LO write.
      if (count == mdu_cnt_t'(1)) begin
        {hi, lo} <= next_hilo;
        count    <= '0;
        state    <= S_IDLE;
        busy     <= 1'b0;
      end else begin
        count <= count - mdu_cnt_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench: stimulus pushes expected {hi,lo,latency}; a monitor checks each busy fall.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_if bus ();

  mult_div_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bus.start),
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .we     (bus.we),
    .cancel (bus.cancel),
    .busy   (bus.busy),
    .hi     (bus.hi),
    .lo     (bus.lo)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic push_exp(input string nm, input logic [31:0] h, input logic [31:0] l, input int cyc);
    exp_t e;
    e.name = nm; e.hi = h; e.lo = l; e.cycles = cyc;
    sb.push_back(e);
    exp_hi = h;
    exp_lo = l;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic c);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y; bus.cancel = c;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] x, input logic c);
    @(posedge clk); #1;
    bus.we = 1'b1; bus.op = o; bus.a = x; bus.cancel = c;
    @(posedge clk); #1;
    bus.we = 1'b0; bus.cancel = 1'b0;
    $display("mt op=%0d a=%h cancel=%0b", o, x, c);
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !bus.busy) break;
    end
    if (k == 40) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got pending=%0d busy=%0b, expected drained", nm, sb.size(), bus.busy);
    end
  endtask

  task automatic idle_check(input string nm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(nm, 32'(bus.busy), 32'd0);
    end
  endtask

  // Monitor: count busy cycles, compare on every falling edge of busy outside reset.
  initial begin
    static bit prev = 1'b0;
    static int cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0; cnt = 0;
      end else if (bus.busy) begin
        cnt++; prev = 1'b1;
      end else begin
        if (prev) begin
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got hi=%h lo=%h, expected no completion", bus.hi, bus.lo);
          end else begin
            e = sb.pop_front();
            $display("done %s hi=%h lo=%h busy_cycles=%0d", e.name, bus.hi, bus.lo, cnt);
            chk({e.name, "_hi"}, bus.hi, e.hi);
            chk({e.name, "_lo"}, bus.lo, e.lo);
            chk({e.name, "_cycles"}, 32'(cnt), 32'(e.cycles));
          end
        end
        prev = 1'b0; cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start = 1'b0; bus.op = 4'd0; bus.a = '0; bus.b = '0; bus.we = 1'b0; bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);

    // Start lands on the first edge after release.
    rst_n = 1'b1;
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'hFFFF_FFFE; bus.b = 32'd3;
    push_exp("mult_neg2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_CYCLES);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("mult_neg2x3");

    push_exp("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYCLES);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("div_m7_2");

    push_exp("div_7_m2", 32'd1, 32'hFFFF_FFFD, DIV_CYCLES);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_done("div_7_m2");

    push_exp("divu_7_0", 32'd7, 32'hFFFF_FFFF, DIV_CYCLES);
    issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
    wait_done("divu_7_0");

    push_exp("div_ovf", 32'd0, 32'h8000_0000, DIV_CYCLES);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div_ovf");

    push_exp("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, MUL_CYCLES);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("multu_max");

    // Cancelled start and cancelled MTLO leave state untouched.
    issue(OP_MULTU, 32'd3, 32'd4, 1'b1);
    idle_check("cancel_start_busy", 3);
    chk("cancel_start_hi", bus.hi, exp_hi);
    chk("cancel_start_lo", bus.lo, exp_lo);
    mt(OP_MTLO, 32'd5, 1'b1);
    chk("cancel_mtlo_lo", bus.lo, exp_lo);

    mt(OP_MTLO, 32'd5, 1'b0);
    exp_lo = 32'd5;
    chk("mtlo_lo", bus.lo, exp_lo);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    mt(OP_MTHI, 32'h1234_5678, 1'b0);
    exp_hi = 32'h1234_5678;
    chk("mthi_hi", bus.hi, exp_hi);
    chk("mthi_lo", bus.lo, exp_lo);

    // Second start and a write strobe during RUN must not disturb the MULTU.
    push_exp("multu_mid", 32'd0, 32'd42, MUL_CYCLES);
    issue(OP_MULTU, 32'd6, 32'd7, 1'b0);
    issue(OP_DIVU, 32'd100, 32'd3, 1'b0);
    mt(OP_MTHI, 32'hDEAD_BEEF, 1'b0);
    wait_done("multu_mid");
    idle_check("multu_mid_idle", 2);
    chk("multu_mid_hold_hi", bus.hi, exp_hi);

    issue(4'hF, 32'd1, 32'd1, 1'b0);
    idle_check("unknown_op_busy", 2);

`ifdef MDU_MADD_EN
    mt(OP_MTHI, 32'd0, 1'b0);
    mt(OP_MTLO, 32'hFFFF_FFFF, 1'b0);
    push_exp("maddu_1x1", 32'd1, 32'd0, MUL_CYCLES);
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
    wait_done("maddu_1x1");
    push_exp("msub_1x1", 32'd0, 32'hFFFF_FFFF, MUL_CYCLES);
    issue(OP_MSUB, 32'd1, 32'd1, 1'b0);
    wait_done("msub_1x1");
`else
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
    idle_check("madd_disabled_busy", 2);
    chk("madd_disabled_lo", bus.lo, exp_lo);
`endif

    // Reset in RUN cycle 4 of a DIV discards the pending result immediately.
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_hi", bus.hi, 32'd0);
    chk("rst_mid_lo", bus.lo, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    push_exp("mult_2x2", 32'd0, 32'd4, MUL_CYCLES);
    issue(OP_MULT, 32'd2, 32'd2, 1'b0);
    wait_done("mult_2x2");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
